// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end for the multicycle MIPS datapath.
// Owns the PC and IR, runs the instruction-memory req/ack handshake and
// applies control-selected PC updates.
// Optional build macro: FETCH_TIMEOUT_EN adds a WAIT-state timeout that
// aborts the fetch and raises the sticky fetch_err flag.
module instr_fetch_unit #(
  parameter int unsigned            DATA_W   = 32,
  parameter logic [DATA_W-1:0]      PC_RESET = '0,
  parameter int unsigned            TIMEOUT  = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              imem_read,
  input  logic              ir_write,
  input  logic              pc_write,
  input  logic              pc_write_cond,
  input  logic [1:0]        pc_source,
  input  logic              zero,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] alu_out,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic [4:0]        op,
  output logic              fetch_busy,
  output logic              fetch_done,
  output logic              fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;

  // Reject out-of-range timeout values at elaboration
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("instr_fetch_unit: TIMEOUT must be in 1..255");
  end

`ifdef FETCH_TIMEOUT_EN
  // Counter value during the last WAIT cycle allowed before abort
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;
`endif

  // Busy and opcode are pure decodes of registered state
  assign fetch_busy = (state == S_WAIT);
  assign op         = instr[31:27];

  // Fetch handshake FSM with registered request, IR and status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      instr      <= '0;
      fetch_done <= 1'b0;
      fetch_err  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt   <= 8'd0;
`endif
    end else begin
      fetch_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (imem_read && ir_write) begin
            mem_addr <= pc;
            mem_req  <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt <= 8'd0;
`endif
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            instr      <= mem_rdata;
            mem_req    <= 1'b0;
            fetch_done <= 1'b1;
            state      <= S_DONE;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wait_cnt == TIMEOUT_LAST) begin
            instr      <= '0;
            mem_req    <= 1'b0;
            fetch_err  <= 1'b1;
            fetch_done <= 1'b1;
            state      <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // PC update, independent of the fetch FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= PC_RESET;
    end else if (pc_write || (pc_write_cond && zero)) begin
      case (pc_source)
        2'd0:    pc <= alu_result;
        2'd1:    pc <= alu_out;
        2'd2:    pc <= {pc[DATA_W-1:28], instr[25:0], 2'b00};
        default: pc <= pc;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed steps plus a randomized
// phase checked against a transaction-level PC/IR reference model.
module tb_instr_fetch_unit;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TMO    = 3;

  logic              clock;
  logic              reset;
  logic              imem_read;
  logic              ir_write;
  logic              pc_write;
  logic              pc_write_cond;
  logic [1:0]        pc_source;
  logic              zero;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] alu_out;
  logic              mem_req;
  logic [DATA_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] instr;
  logic [4:0]        op;
  logic              fetch_busy;
  logic              fetch_done;
  logic              fetch_err;

  instr_fetch_unit #(
    .DATA_W  (DATA_W),
    .PC_RESET(32'h0),
    .TIMEOUT (TMO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .imem_read    (imem_read),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .pc_source    (pc_source),
    .zero         (zero),
    .alu_result   (alu_result),
    .alu_out      (alu_out),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .pc           (pc),
    .instr        (instr),
    .op           (op),
    .fetch_busy   (fetch_busy),
    .fetch_done   (fetch_done),
    .fetch_err    (fetch_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_err;

  // Rising edges of mem_req seen on the bus
  int   req_rises = 0;
  logic req_q     = 1'b0;
  always @(posedge clock) begin
    if (mem_req && !req_q) req_rises = req_rises + 1;
    req_q = mem_req;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock, updating the PC model from the inputs applied
  task automatic tick();
    logic [31:0] exp_pc;
    exp_pc = m_pc;
    if (reset) begin
      exp_pc = 32'h0;
    end else if (pc_write || (pc_write_cond && zero)) begin
      if (pc_source == 2'd0) exp_pc = alu_result;
      else if (pc_source == 2'd1) exp_pc = alu_out;
      else if (pc_source == 2'd2) exp_pc = (m_pc & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
    end
    @(posedge clock);
    #1;
    m_pc = exp_pc;
    chk("pc", pc, m_pc);
  endtask

  task automatic rand_pc_ctrl();
    pc_write      = ($urandom_range(0, 3) == 0);
    pc_write_cond = 1'($urandom_range(0, 1));
    zero          = 1'($urandom_range(0, 1));
    pc_source     = 2'($urandom_range(0, 3));
    alu_result    = $urandom;
    alu_out       = $urandom;
  endtask

  task automatic clr_ctrl();
    imem_read = 1'b0; ir_write = 1'b0; pc_write = 1'b0; pc_write_cond = 1'b0;
    pc_source = 2'd0; zero = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] word;
    logic [31:0] exp_addr;
    int          rises0;
    int          dly;

    m_pc = 32'h0; m_instr = 32'h0; m_err = 1'b0;
    clr_ctrl();
    alu_result = '0; alu_out = '0; mem_rdata = '0;

    // Reset values
    reset = 1'b1;
    tick(); tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_op", 32'(op), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_busy", 32'(fetch_busy), 32'h0);
    chk("rst_done", 32'(fetch_done), 32'h0);
    chk("rst_err", 32'(fetch_err), 32'h0);
    reset = 1'b0;

    // First fetch with PC+4 in the same cycle
    imem_read = 1'b1; ir_write = 1'b1; pc_write = 1'b1; pc_source = 2'd0; alu_result = 32'h4;
    tick();
    clr_ctrl();
    chk("f1_req", 32'(mem_req), 32'h1);
    chk("f1_addr", mem_addr, 32'h0);
    chk("f1_pc", pc, 32'h4);
    chk("f1_busy", 32'(fetch_busy), 32'h1);
    chk("f1_done0", 32'(fetch_done), 32'h0);
    tick();
    chk("f1_req_hold", 32'(mem_req), 32'h1);
    chk("f1_done1", 32'(fetch_done), 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h2000_0005;
    tick();
    mem_ack = 1'b0; m_instr = 32'h2000_0005;
    chk("f1_instr", instr, 32'h2000_0005);
    chk("f1_op", 32'(op), 32'h4);
    chk("f1_done", 32'(fetch_done), 32'h1);
    chk("f1_req_drop", 32'(mem_req), 32'h0);
    tick();
    chk("f1_done_pulse", 32'(fetch_done), 32'h0);
    chk("f1_idle", 32'(fetch_busy), 32'h0);

    // Conditional branch taken / not taken
    pc_write_cond = 1'b1; zero = 1'b1; pc_source = 2'd1; alu_out = 32'h40;
    tick();
    chk("br_taken", pc, 32'h40);
    zero = 1'b0; alu_out = 32'h80;
    tick();
    chk("br_not_taken", pc, 32'h40);
    clr_ctrl();

    // Jump: set PC, load IR, then jump and hold
    pc_write = 1'b1; pc_source = 2'd0; alu_result = 32'h1000_0008;
    tick();
    clr_ctrl();
    imem_read = 1'b1; ir_write = 1'b1;
    tick();
    clr_ctrl();
    chk("j_addr", mem_addr, 32'h1000_0008);
    mem_ack = 1'b1; mem_rdata = 32'h0800_0010;
    tick();
    mem_ack = 1'b0; m_instr = 32'h0800_0010;
    tick();
    pc_write = 1'b1; pc_source = 2'd2;
    tick();
    chk("jump_pc", pc, 32'h1000_0040);
    pc_source = 2'd3;
    tick();
    chk("hold_pc", pc, 32'h1000_0040);
    clr_ctrl();

    // Reset in WAIT, late ack ignored
    imem_read = 1'b1; ir_write = 1'b1;
    tick();
    clr_ctrl();
    chk("rw_busy", 32'(fetch_busy), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0; m_instr = 32'h0;
    chk("rw_req", 32'(mem_req), 32'h0);
    chk("rw_busy0", 32'(fetch_busy), 32'h0);
    chk("rw_pc", pc, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rw_instr", instr, 32'h0);
      chk("rw_nodone", 32'(fetch_done), 32'h0);
    end
    mem_ack = 1'b0;

    // imem_read pulsed during WAIT is ignored
    rises0 = req_rises;
    imem_read = 1'b1; ir_write = 1'b1; pc_write = 1'b1; pc_source = 2'd0; alu_result = 32'h100;
    tick();
    for (int i = 0; i < 3; i++) begin
      imem_read = 1'(i % 2); ir_write = 1'(i % 2); alu_result = 32'h200 + 32'(i);
      tick();
      chk("wq_addr", mem_addr, 32'h0);
      chk("wq_req", 32'(mem_req), 32'h1);
    end
    clr_ctrl();
    mem_ack = 1'b1; mem_rdata = 32'h8800_0123;
    tick();
    mem_ack = 1'b0; m_instr = 32'h8800_0123;
    chk("wq_instr", instr, 32'h8800_0123);
    tick();
    chk("wq_rises", 32'(req_rises - rises0), 32'h1);

    // No ack: timeout abort or indefinite wait depending on build
    imem_read = 1'b1; ir_write = 1'b1;
    tick();
    clr_ctrl();
`ifdef FETCH_TIMEOUT_EN
    chk("to_req1", 32'(mem_req), 32'h1);
    tick();
    chk("to_req2", 32'(mem_req), 32'h1);
    tick();
    chk("to_req3", 32'(mem_req), 32'h1);
    chk("to_err0", 32'(fetch_err), 32'h0);
    tick();
    m_instr = 32'h0; m_err = 1'b1;
    chk("to_req_drop", 32'(mem_req), 32'h0);
    chk("to_done", 32'(fetch_done), 32'h1);
    chk("to_err", 32'(fetch_err), 32'h1);
    chk("to_instr", instr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_done_once", 32'(fetch_done), 32'h0);
      chk("to_err_sticky", 32'(fetch_err), 32'h1);
    end
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("nt_req", 32'(mem_req), 32'h1);
      chk("nt_err", 32'(fetch_err), 32'h0);
      chk("nt_done", 32'(fetch_done), 32'h0);
    end
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0; m_instr = 32'h1234_5678;
    chk("nt_instr", instr, 32'h1234_5678);
    tick();
`endif

    // Randomized phase against the reference model
    for (int it = 0; it < 200; it++) begin
      rand_pc_ctrl();
      if ($urandom_range(0, 3) == 0) begin
        imem_read = 1'b1; ir_write = 1'b1; exp_addr = m_pc;
        tick();
        imem_read = 1'b0; ir_write = 1'b0;
        chk("r_req", 32'(mem_req), 32'h1);
        chk("r_addr", mem_addr, exp_addr);
        chk("r_busy", 32'(fetch_busy), 32'h1);
        dly = int'($urandom_range(0, TMO - 1));
        for (int d = 0; d < dly; d++) begin
          rand_pc_ctrl();
          imem_read = 1'($urandom_range(0, 1)); ir_write = imem_read;
          tick();
          chk("r_wait_req", 32'(mem_req), 32'h1);
          chk("r_wait_addr", mem_addr, exp_addr);
          chk("r_wait_done", 32'(fetch_done), 32'h0);
        end
        imem_read = 1'b0; ir_write = 1'b0;
        word = $urandom; mem_ack = 1'b1; mem_rdata = word;
        rand_pc_ctrl();
        tick();
        mem_ack = 1'b0; m_instr = word;
        chk("r_instr", instr, m_instr);
        chk("r_op", 32'(op), m_instr >> 27);
        chk("r_done", 32'(fetch_done), 32'h1);
        chk("r_req_drop", 32'(mem_req), 32'h0);
        rand_pc_ctrl();
        tick();
        chk("r_done_pulse", 32'(fetch_done), 32'h0);
        chk("r_idle", 32'(fetch_busy), 32'h0);
      end else begin
        mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        imem_read = 1'($urandom_range(0, 1)); ir_write = 1'b0;
        tick();
        mem_ack = 1'b0; imem_read = 1'b0;
        chk("r_idle_instr", instr, m_instr);
        chk("r_idle_req", 32'(mem_req), 32'h0);
        chk("r_idle_done", 32'(fetch_done), 32'h0);
      end
      chk("r_err", 32'(fetch_err), 32'(m_err));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the multicycle MIPS datapath, directly upstream of the control FSM.
- Owns the PC and the instruction register (IR).
- Runs the instruction-memory request/acknowledge handshake when control asserts imem_read with ir_write.
- Presents op[4:0] back to control, and applies PC updates selected by pc_write, pc_write_cond and pc_source.

Parameters:
- DATA_W, 32, width of PC, IR, memory address and data.
- PC_RESET, 0, PC value loaded on reset.
- TIMEOUT, 15, cycles in WAIT without mem_ack before abort. Legal range 1..255; 8-bit counter.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- imem_read  in  1  control: start instruction fetch
- ir_write  in  1  control: capture fetched word into IR
- pc_write  in  1  control: unconditional PC update
- pc_write_cond  in  1  control: PC update if zero=1
- pc_source  in  2  PC source select: 0 alu_result, 1 alu_out, 2 jump target, 3 hold
- zero  in  1  ALU zero flag
- alu_result  in  DATA_W  combinational ALU output (PC+4)
- alu_out  in  DATA_W  registered ALU output (branch target)
- mem_req  out  1  instruction memory request, registered
- mem_addr  out  DATA_W  fetch address, registered
- mem_ack  in  1  memory returns mem_rdata valid this cycle
- mem_rdata  in  DATA_W  fetched instruction word
- pc  out  DATA_W  current PC
- instr  out  DATA_W  IR contents
- op  out  5  instr[31:27], to control
- fetch_busy  out  1  high while fetch outstanding
- fetch_done  out  1  one-cycle pulse when IR loaded
- fetch_err  out  1  sticky timeout flag

Behaviour:
- Reset (sync, active-high) values:
  - pc=PC_RESET; instr=0; op=0.
  - mem_req=0; mem_addr=0.
  - fetch_busy=0; fetch_done=0; fetch_err=0.
  - state=IDLE; timeout counter=0.
  - Reset overrides all other inputs, including mid-fetch. An mem_ack arriving after reset is ignored.
- FSM states:
  - IDLE:
    - If imem_read && ir_write: mem_addr<=pc (old PC), mem_req<=1, counter<=0, go WAIT.
    - imem_read without ir_write: no action.
  - WAIT:
    - fetch_busy=1 (combinational from state).
    - mem_ack is sampled only here. On mem_ack: instr<=mem_rdata, mem_req<=0, fetch_done<=1, go DONE.
    - Otherwise counter increments.
    - imem_read in WAIT is ignored (no queueing).
  - DONE: fetch_done high for exactly this one cycle; return to IDLE. A new fetch may start the cycle after DONE.
- Fetch latency: request registered 1 cycle after imem_read; IR valid 1 cycle after mem_ack. Minimum 2 cycles imem_read->fetch_done.
- PC update is independent of the FSM:
  - Update condition, evaluated every cycle: pc_write || (pc_write_cond && zero).
  - Source, per pc_source:
    - 0: alu_result.
    - 1: alu_out.
    - 2: {pc[DATA_W-1:28], instr[25:0], 2'b00}.
    - 3: no change, even if enabled.
  - Because mem_addr latches the old PC, pc_write in the same cycle as imem_read is legal and required (PC+4 on fetch).
- op is combinational from instr[31:27]. Stable from fetch_done until the next IR load.
- mem_ack in IDLE or DONE is ignored.
- Widths: all DATA_W, no arithmetic inside the block. Low 2 bits of PC are not forced.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - When counter reaches TIMEOUT in WAIT without mem_ack: mem_req<=0, instr<=0, fetch_err<=1, fetch_done<=1, go DONE.
  - An ack on the timeout cycle wins over the timeout.
  - fetch_err clears only on reset.
- Undefined: no counter; WAIT persists until mem_ack; fetch_err tied to 0.

Test Plan:
- Reset then imem_read=ir_write=pc_write=1, pc_source=0, alu_result=4 for 1 cycle; mem_ack with mem_rdata=0x2000_0005 two cycles later.
  - Required: mem_addr=0, mem_req high until ack, pc=4, instr=0x2000_0005, op=0x04, one fetch_done pulse.
- Branch: pc_write_cond=1, zero=1, pc_source=1, alu_out=0x40.
  - Required: pc=0x40 next cycle.
  - Repeat with zero=0: pc unchanged.
- Jump: instr=0x0800_0010, pc=0x1000_0008, pc_write=1, pc_source=2.
  - Required: pc=0x1000_0040.
  - pc_source=3 with pc_write=1: pc unchanged.
- Reset asserted in WAIT.
  - Required: next cycle mem_req=0, state IDLE, pc=PC_RESET.
  - A following mem_ack leaves instr=0 and gives no fetch_done.
- FETCH_TIMEOUT_EN defined, TIMEOUT=3, no mem_ack.
  - Required: mem_req drops after 3 WAIT cycles, fetch_err=1 sticky, instr=0, single fetch_done.
  - Undefined build: mem_req stays high for 20 cycles, fetch_err=0.
- imem_read pulsed again during WAIT.
  - Required: ignored; exactly one mem_req rising edge; mem_addr unchanged.
